// File: rtl/wddl_aes_pkg.sv
// Shared constants and types for the WDDL AES-128 key schedule.
package wddl_aes_pkg;

    localparam int NR = 10;

    typedef logic [31:0] word32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);

    // Entry i lives at index i; with ascending packed order, index 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX_TBL[x];

endmodule

// File: rtl/wddl_key_expand.sv
// Iterative AES-128 key schedule with dual-rail (WDDL) registered round-key outputs.
// Define WDDL_PRECHARGE_EN to insert a precharge (spacer) cycle before every evaluate cycle.
module wddl_key_expand #(
    parameter int NR    = wddl_aes_pkg::NR,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [KEY_W-1:0] key,
    output logic [31:0]      w0,
    output logic [31:0]      w1,
    output logic [31:0]      w2,
    output logic [31:0]      w3,
    output logic [31:0]      w0_n,
    output logic [31:0]      w1_n,
    output logic [31:0]      w2_n,
    output logic [31:0]      w3_n,
    output logic             kvalid,
    output logic [3:0]       kround,
    output logic             kdone
);

    import wddl_aes_pkg::*;

    state_t     state, state_d;
    word32_t    kw [0:3];
    word32_t    kw_d [0:3];
    word32_t    step_w [0:3];
    word32_t    rot_w3, sub_w3;
    logic [7:0] rcon, rcon_d;
    logic [3:0] kround_d;
    logic       kvalid_d, kdone_d;

    assign rot_w3 = {kw[3][23:0], kw[3][31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .x (rot_w3[8*i +: 8]),
            .y (sub_w3[8*i +: 8])
        );
    end

    // Next round key from the current one; each word chains on the freshly computed previous word.
    assign step_w[0] = kw[0] ^ sub_w3 ^ {rcon, 24'h0};
    assign step_w[1] = kw[1] ^ step_w[0];
    assign step_w[2] = kw[2] ^ step_w[1];
    assign step_w[3] = kw[3] ^ step_w[2];

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves one unassigned (no latch).
        state_d  = state;
        kw_d     = kw;
        rcon_d   = rcon;
        kround_d = kround;
        kvalid_d = kvalid;
        kdone_d  = 1'b0;

        if (ld) begin
            kw_d[0]  = key[127:96];
            kw_d[1]  = key[95:64];
            kw_d[2]  = key[63:32];
            kw_d[3]  = key[31:0];
            rcon_d   = RCON[0];
            kround_d = 4'd0;
            state_d  = RUN;
`ifdef WDDL_PRECHARGE_EN
            kvalid_d = 1'b0;
`else
            kvalid_d = 1'b1;
`endif
        end else begin
            case (state)
                RUN: begin
`ifdef WDDL_PRECHARGE_EN
                    // Advance the key on the way into precharge; the new round shows on the following evaluate.
                    if (!kvalid) begin
                        kvalid_d = 1'b1;
                        if (kround == 4'(NR)) begin
                            state_d = HOLD;
                            kdone_d = 1'b1;
                        end
                    end else begin
                        kw_d     = step_w;
                        rcon_d   = xtime(rcon);
                        kround_d = kround + 4'd1;
                        kvalid_d = 1'b0;
                    end
`else
                    kw_d     = step_w;
                    rcon_d   = xtime(rcon);
                    kround_d = kround + 4'd1;
                    if (kround_d == 4'(NR)) begin
                        state_d = HOLD;
                        kdone_d = 1'b1;
                    end
`endif
                end
                HOLD: begin
`ifdef WDDL_PRECHARGE_EN
                    kvalid_d = ~kvalid;
`endif
                end
                default: ;
            endcase
        end
    end

    // Rails are registered from next-state values, so outputs never depend combinationally on key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            kw     <= '{default: '0};
            rcon   <= 8'h01;
            kround <= 4'd0;
            kvalid <= 1'b0;
            kdone  <= 1'b0;
            w0     <= '0;
            w1     <= '0;
            w2     <= '0;
            w3     <= '0;
            w0_n   <= '0;
            w1_n   <= '0;
            w2_n   <= '0;
            w3_n   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state  <= state_d;
            kw     <= kw_d;
            rcon   <= rcon_d;
            kround <= kround_d;
            kvalid <= kvalid_d;
            kdone  <= kdone_d;
            w0     <= kvalid_d ? kw_d[0] : '0;
            w1     <= kvalid_d ? kw_d[1] : '0;
            w2     <= kvalid_d ? kw_d[2] : '0;
            w3     <= kvalid_d ? kw_d[3] : '0;
            w0_n   <= kvalid_d ? ~kw_d[0] : '0;
            w1_n   <= kvalid_d ? ~kw_d[1] : '0;
            w2_n   <= kvalid_d ? ~kw_d[2] : '0;
            w3_n   <= kvalid_d ? ~kw_d[3] : '0;
        end
    end

endmodule

// File: tb/tb_wddl_key_expand.sv
// Directed self-checking bench for wddl_key_expand using FIPS-197 and all-zero key vectors.
module tb_wddl_key_expand;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ld  = 1'b0;
    logic [127:0] key = '0;
    logic [31:0]  w0, w1, w2, w3, w0_n, w1_n, w2_n, w3_n;
    logic         kvalid, kdone;
    logic [3:0]   kround;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    wddl_key_expand dut (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .key    (key),
        .w0     (w0),
        .w1     (w1),
        .w2     (w2),
        .w3     (w3),
        .w0_n   (w0_n),
        .w1_n   (w1_n),
        .w2_n   (w2_n),
        .w3_n   (w3_n),
        .kvalid (kvalid),
        .kround (kround),
        .kdone  (kdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Dual-rail integrity on every cycle, whatever the main sequence is doing.
    always @(negedge clk) begin
        if (kvalid === 1'b1)
            check("rail_compl", {w0_n, w1_n, w2_n, w3_n}, ~{w0, w1, w2, w3});
        else
            check("rail_spacer", {w0, w1, w2, w3} | {w0_n, w1_n, w2_n, w3_n}, 128'h0);
    end

    task automatic expect_key(input string tag, input logic [3:0] rnd,
                              input logic [127:0] rk, input logic done);
        check({tag, "_kvalid"}, 128'(kvalid), 128'(1'b1));
        check({tag, "_kround"}, 128'(kround), 128'(rnd));
        check({tag, "_rails"}, {w0, w1, w2, w3}, rk);
        check({tag, "_kdone"}, 128'(kdone), 128'(done));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_kvalid"}, 128'(kvalid), 128'(1'b0));
        check({tag, "_kround"}, 128'(kround), 128'(4'd0));
        check({tag, "_kdone"}, 128'(kdone), 128'(1'b0));
        check({tag, "_rails"}, {w0, w1, w2, w3, w0_n, w1_n, w2_n, w3_n}, 256'h0);
    endtask

    // Called at a negedge: pulse ld across the next posedge, return at the following negedge.
    task automatic load(input logic [127:0] k);
        ld  = 1'b1;
        key = k;
        @(negedge clk);
        ld  = 1'b0;
    endtask

    initial begin
        #3;
        expect_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_idle("idle");

`ifdef WDDL_PRECHARGE_EN
        load(FIPS_KEY);
        for (int j = 1; j <= 22; j++) begin
            if (j % 2 == 1)
                check($sformatf("pc_spacer%0d", j), 128'(kvalid), 128'(1'b0));
            else
                expect_key($sformatf("pc_eval%0d", j), 4'((j - 2) / 2), fips_rk[(j - 2) / 2], j == 22);
            if (j < 22) @(negedge clk);
        end
        @(negedge clk);
        check("pc_hold_spacer", 128'(kvalid), 128'(1'b0));
        @(negedge clk);
        expect_key("pc_hold_eval", 4'd10, fips_rk[10], 1'b0);

        load(FIPS_KEY);
        check("pc_reload_spacer", 128'(kvalid), 128'(1'b0));
        @(negedge clk);
        expect_key("pc_reload_r0", 4'd0, FIPS_KEY, 1'b0);
`else
        load(FIPS_KEY);
        for (int k = 0; k <= 10; k++) begin
            expect_key($sformatf("fips_r%0d", k), 4'(k), fips_rk[k], k == 10);
            if (k < 10) @(negedge clk);
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            expect_key($sformatf("fips_hold%0d", h), 4'd10, fips_rk[10], 1'b0);
        end

        load(128'h0);
        for (int k = 0; k <= 10; k++) begin
            if (k == 1) expect_key("zero_r1", 4'd1, ZERO_RK1, 1'b0);
            if (k == 10) expect_key("zero_r10", 4'd10, ZERO_RK10, 1'b1);
            if (k < 10) @(negedge clk);
        end
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            expect_key($sformatf("zero_hold%0d", h), 4'd10, ZERO_RK10, 1'b0);
        end

        load(FIPS_KEY);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        expect_key("pre_reload_r5", 4'd5, fips_rk[5], 1'b0);
        load(FIPS_KEY);
        for (int k = 0; k <= 10; k++) begin
            expect_key($sformatf("reload_r%0d", k), 4'(k), fips_rk[k], k == 10);
            if (k < 10) @(negedge clk);
        end

        ld  = 1'b1;
        key = 128'h0;
        @(negedge clk);
        expect_key("cont_ld_a", 4'd0, 128'h0, 1'b0);
        key = FIPS_KEY;
        @(negedge clk);
        expect_key("cont_ld_b", 4'd0, FIPS_KEY, 1'b0);
        ld = 1'b0;
        @(negedge clk);
        expect_key("cont_ld_r1", 4'd1, fips_rk[1], 1'b0);
`endif

        load(FIPS_KEY);
        for (int k = 0; k < 5; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1 expect_idle("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            expect_idle($sformatf("post_rst%0d", h));
        end
        load(FIPS_KEY);
`ifdef WDDL_PRECHARGE_EN
        @(negedge clk);
`endif
        expect_key("after_rst_r0", 4'd0, FIPS_KEY, 1'b0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wddl_key_expand.md
Name: wddl_key_expand

Overview:
Iterative AES-128 key schedule that feeds round keys to the WDDL AES datapath, one round key per evaluate step.
- Loads the cipher key on ld and produces round keys 0..10 as four 32-bit words on dual rails (true/complement), with a round index and strobes.
- Sits directly upstream of the round datapath. The datapath consumes w0..w3 / w0_n..w3_n in lockstep with kround.

Parameters:
NR, 10, number of AES rounds (AES-128 only; other values unsupported)
KEY_W, 128, cipher key width in bits

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
ld  input  1  load strobe; samples key and restarts the schedule
key  input  KEY_W  cipher key; key[127:96] is word 0
w0  output  32  round key word 0, true rail
w1  output  32  round key word 1, true rail
w2  output  32  round key word 2, true rail
w3  output  32  round key word 3, true rail
w0_n  output  32  round key word 0, complement rail
w1_n  output  32  round key word 1, complement rail
w2_n  output  32  round key word 2, complement rail
w3_n  output  32  round key word 3, complement rail
kvalid  output  1  round key on the rails is valid (evaluate phase)
kround  output  4  index 0..NR of the round key currently presented
kdone  output  1  one-cycle pulse with the final round key (kround==NR)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async assert, any state, mid-schedule included):
  - State=IDLE.
  - Internal key words=0, rcon=8'h01.
  - kvalid=0, kround=0, kdone=0.
  - All eight rail outputs=0 (spacer).
- Spacer rule: whenever kvalid=0, both rails of every word are driven 0. Whenever kvalid=1, wX_n == ~wX bit-for-bit.
- FSM states: IDLE, RUN, HOLD.
  - IDLE --ld--> RUN.
  - RUN: kround increments each evaluate step; when kround==NR, go to HOLD.
  - HOLD: outputs frozen at round NR key, kvalid=1, until ld or rst.
  - ld has priority in every state. A ld during RUN aborts and restarts from the new key next cycle.
- Load timing: ld sampled at edge t.
  - At t+1: rails = key, kround=0, kvalid=1, rcon=8'h01.
- Step (no macro): each edge in RUN computes
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - rcon' = xtime(rcon): 01,02,04,08,10,20,40,80,1b,36
  - Round k key appears at t+1+k; round 10 at t+11.
- kdone is high exactly one cycle: the first cycle kround==NR with kvalid=1. Not reasserted in HOLD.
- kround saturates at NR and never wraps.
- ld asserted continuously reloads every cycle: kround stays 0, kvalid=1.
- Key bits are not used combinationally on outputs; all outputs are registered.

Optional Feature:
Macro WDDL_PRECHARGE_EN.
- Defined: each round key occupies two cycles, a precharge cycle then an evaluate cycle.
  - Precharge cycle: kvalid=0, all rails 0.
  - Evaluate cycle: kvalid=1, complementary rails.
  - After ld at edge t: precharge at t+1, round 0 evaluate at t+2, round k evaluate at t+2+2k (round 10 at t+22).
  - HOLD alternates precharge/evaluate continuously.
  - ld is accepted in either phase and restarts from precharge.
- Undefined: single-phase behaviour above; no spacer cycles after load.

Decomposition:
- Package wddl_aes_pkg:
  - NR constant
  - state enum typedef {IDLE,RUN,HOLD}
  - RCON array of 10 bytes
  - word32_t typedef
  - function xtime
- One sub-module, aes_sbox: combinational byte S-box, instantiated 4 times for SubWord.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ld 1 cycle:
  - t+1: kround=0, rails=key.
  - t+2: w0..w3=a0fafe17 88542cb1 23a33939 2a6c7605.
  - t+11: d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with kdone=1.
- All-zero key:
  - round 1 = 62636363 x4.
  - round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
  - HOLD keeps this value; kdone is low thereafter.
- Rail check every cycle: kvalid=1 implies wX_n==~wX; kvalid=0 implies all rails 0.
- Reload at kround=5 with the FIPS key: next cycle kround=0, rails=key; the schedule completes correctly from there.
- rst asserted asynchronously mid-RUN (between edges): outputs go to 0/spacer immediately. kvalid=0 and IDLE hold until the next ld.
- With WDDL_PRECHARGE_EN, FIPS key: round 1 evaluate at t+4; round 10 at t+22. Every odd cycle after ld is a spacer.
